// File: rtl/spi_keycode_slave.sv
// SPI mode-0 keycode injector: 2-byte frames {cmd, data} feed a small keycode FIFO; a status byte is readable over MISO.
// Optional feature macro SPI_KEY_OVF_CNT_EN: saturating dropped-keycode counter, read back with cmd 8'h03.
module spi_keycode_slave #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] CMD_WR   = 8'h01,
    parameter logic [7:0] CMD_STAT = 8'h02
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] keycode,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       ovf,
    output logic [7:0] ovf_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    // Synchronizers carry no reset so a reset cannot fabricate an ss_n edge from stale stage values.
    logic [2:0] sync1_reg, sync2_reg;   // {sclk, ss_n, mosi}
    logic [1:0] prev_reg;               // {sclk, ss_n} one cycle later, for edge detection

    always_ff @(posedge Clk) begin
        sync1_reg <= {sclk, ss_n, mosi};
        sync2_reg <= sync1_reg;
        prev_reg  <= sync2_reg[2:1];
    end

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_s, mosi_s;
    assign sclk_rise = sync2_reg[2] & ~prev_reg[1];
    assign sclk_fall = ~sync2_reg[2] & prev_reg[1];
    assign ss_s      = sync2_reg[1];
    assign ss_rise   = ss_s & ~prev_reg[0];
    assign ss_fall   = ~ss_s & prev_reg[0];
    assign mosi_s    = sync2_reg[0];

    state_t           state_reg;
    logic [2:0]       bit_cnt_reg;
    logic [6:0]       shift_reg;
    logic [7:0]       cmd_reg;
    logic [7:0]       miso_shift_reg;
    logic             miso_reg, miso_oe_reg;
    logic             push_reg, clr_reg;
    logic [7:0]       push_data_reg;
    logic [7:0]       byte_in;
    logic [7:0]       reply_byte;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [3:0]       count_reg;
    logic             ovf_reg;
    logic             pop, accept, drop;

    assign byte_in = {shift_reg, mosi_s};

`ifdef SPI_KEY_OVF_CNT_EN
    localparam logic [7:0] CMD_CNT = 8'h03;
    logic [7:0] ovf_cnt_reg;
`endif

    // Reply for the data byte, snapshotted when the cmd byte completes.
    always_comb begin
        reply_byte = 8'h00;
        if (byte_in == CMD_STAT)
            reply_byte = {ovf_reg, 3'b000, count_reg};
`ifdef SPI_KEY_OVF_CNT_EN
        else if (byte_in == CMD_CNT)
            reply_byte = ovf_cnt_reg;
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 7'd0;
            cmd_reg        <= 8'h00;
            miso_shift_reg <= 8'h00;
            miso_reg       <= 1'b0;
            miso_oe_reg    <= 1'b0;
            push_reg       <= 1'b0;
            push_data_reg  <= 8'h00;
            clr_reg        <= 1'b0;
        end else begin
            push_reg    <= 1'b0;
            clr_reg     <= 1'b0;
            miso_oe_reg <= ~ss_s;
            if (ss_rise) begin
                state_reg   <= IDLE;
                bit_cnt_reg <= 3'd0;
                miso_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (ss_fall) begin
                            state_reg   <= CMD;
                            bit_cnt_reg <= 3'd0;
                            miso_reg    <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift_reg   <= byte_in[6:0];
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                cmd_reg        <= byte_in;
                                miso_shift_reg <= reply_byte;
                                state_reg      <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            shift_reg   <= byte_in[6:0];
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= DONE;
                                if (cmd_reg == CMD_WR) begin
                                    push_reg      <= 1'b1;
                                    push_data_reg <= byte_in;
                                end
                                if (cmd_reg == CMD_STAT)
                                    clr_reg <= 1'b1;
                            end
                        end else if (sclk_fall) begin
                            miso_reg       <= miso_shift_reg[7];
                            miso_shift_reg <= {miso_shift_reg[6:0], 1'b0};
                        end
                    end
                    DONE: begin
                        if (sclk_fall)
                            miso_reg <= 1'b0;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted alongside it.
    assign pop    = key_valid & key_ready;
    assign accept = push_reg & ((count_reg != 4'(DEPTH)) | pop);
    assign drop   = push_reg & ~accept;

    always_ff @(posedge Clk) begin
        if (accept)
            mem[wr_ptr_reg] <= push_data_reg;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= 4'd0;
            ovf_reg    <= 1'b0;
        end else begin
            if (pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (accept)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + 4'd1;
                2'b01:   count_reg <= count_reg - 4'd1;
                default: count_reg <= count_reg;
            endcase
            if (drop)
                ovf_reg <= 1'b1;
            else if (clr_reg)
                ovf_reg <= 1'b0;
        end
    end

`ifdef SPI_KEY_OVF_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            ovf_cnt_reg <= 8'h00;
        else if (drop) begin
            if (ovf_cnt_reg != 8'hFF)
                ovf_cnt_reg <= ovf_cnt_reg + 8'h01;
        end else if (clr_reg)
            ovf_cnt_reg <= 8'h00;
    end
    assign ovf_count = ovf_cnt_reg;
`else
    assign ovf_count = 8'h00;
`endif

    assign key_valid = (count_reg != 4'd0);
    assign keycode   = key_valid ? mem[rd_ptr_reg] : 8'h00;
    assign ovf       = ovf_reg;
    assign miso      = miso_reg;
    assign miso_oe   = miso_oe_reg;
endmodule
